// File: rtl/inventory_bank.sv
// Per-channel unit counters with take-edge detection, restock refill and grant/deny pulses.
// Optional low-stock flags are compiled in with INVENTORY_LOW_WARN_EN.
module inventory_bank #(
    parameter int CHANNELS   = 2,
    parameter int CAPACITY   = 3,
    parameter int CNT_W      = 2,
    parameter int LOW_THRESH = 1
) (
    input  logic                      clk1,
    input  logic                      reset1,
    input  logic [CHANNELS-1:0]       take,
    input  logic [CHANNELS-1:0]       restock,
    output logic [CHANNELS-1:0]       avail,
    output logic [CHANNELS-1:0]       grant,
    output logic [CHANNELS-1:0]       deny,
    output logic [CHANNELS*CNT_W-1:0] count,
    output logic                      all_empty,
    output logic [CHANNELS-1:0]       low
);

    localparam logic [CNT_W-1:0] CAP_VAL = CNT_W'(CAPACITY);

    // Elaboration-time guard against parameter sets the counters cannot represent.
    if ((CHANNELS < 1) || (CHANNELS > 8) || (CAPACITY < 1) || (CAPACITY > 255) ||
        ((1 << CNT_W) <= CAPACITY) || (LOW_THRESH < 0) || (LOW_THRESH > 255)) begin : g_bad_params
        $error("inventory_bank: unsupported parameter combination");
    end

    logic [CHANNELS-1:0] take_q;

    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            take_q <= '0;
        end else begin
            take_q <= take;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             take_edge;
            logic             nonzero;

            assign take_edge = take[gi] & ~take_q[gi];
            assign nonzero   = (cnt_q != '0);

            // Restock wins over a coincident take edge; reset suppresses both pulses.
            assign grant[gi] = ~reset1 & ~restock[gi] & take_edge & nonzero;
            assign deny[gi]  = ~reset1 & ~restock[gi] & take_edge & ~nonzero;

            always_comb begin
                cnt_d = cnt_q;
                if (restock[gi]) begin
                    cnt_d = CAP_VAL;
                end else if (take_edge && nonzero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            always_ff @(posedge clk1 or posedge reset1) begin
                if (reset1) begin
                    cnt_q <= CAP_VAL;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign avail[gi]                  = nonzero;
            assign count[gi*CNT_W +: CNT_W]   = cnt_q;

`ifdef INVENTORY_LOW_WARN_EN
            localparam logic [31:0] LOW_VAL = LOW_THRESH;
            assign low[gi] = nonzero && (32'(cnt_q) <= LOW_VAL);
`else
            assign low[gi] = 1'b0;
`endif
        end
    endgenerate

    assign all_empty = ~|avail;

endmodule

// File: tb/tb_inventory_bank.sv
// Directed self-checking bench for inventory_bank with CHANNELS=2, CAPACITY=3, CNT_W=2.
module tb_inventory_bank;

    logic       clk1 = 1'b0;
    logic       reset1;
    logic [1:0] take;
    logic [1:0] restock;
    logic [1:0] avail;
    logic [1:0] grant;
    logic [1:0] deny;
    logic [3:0] count;
    logic       all_empty;
    logic [1:0] low;

    int checks   = 0;
    int failures = 0;

    inventory_bank #(
        .CHANNELS  (2),
        .CAPACITY  (3),
        .CNT_W     (2),
        .LOW_THRESH(1)
    ) dut (
        .clk1     (clk1),
        .reset1   (reset1),
        .take     (take),
        .restock  (restock),
        .avail    (avail),
        .grant    (grant),
        .deny     (deny),
        .count    (count),
        .all_empty(all_empty),
        .low      (low)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected low flag for one channel at a given count (threshold 1).
    function automatic logic low_of(input int c);
`ifdef INVENTORY_LOW_WARN_EN
        return (c != 0) && (c <= 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk1);
        #1;
    endtask

    // One request cycle followed by one idle cycle; pulses are checked mid request cycle.
    task automatic pulse(input string tag, input logic [1:0] t, input logic [1:0] r,
                         input logic [1:0] eg, input logic [1:0] ed);
        take    = t;
        restock = r;
        #1;
        check({tag, "_grant"}, 32'(grant), 32'(eg));
        check({tag, "_deny"},  32'(deny),  32'(ed));
        cyc();
        take    = 2'b00;
        restock = 2'b00;
        cyc();
        $display("txn %s take=%b restock=%b grant=%b deny=%b count=%h", tag, t, r, eg, ed, count);
    endtask

    initial begin
        int gsum;
        reset1  = 1'b1;
        take    = 2'b01;
        restock = 2'b00;
        #2;
        check("rst_count", 32'(count), 32'hF);
        check("rst_avail", 32'(avail), 32'h3);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_deny", 32'(deny), 32'h0);
        check("rst_all_empty", 32'(all_empty), 32'h0);
        check("rst_low", 32'(low), {30'b0, low_of(3), low_of(3)});
        cyc();
        reset1 = 1'b0;
        #1;
        check("release_edge_grant", 32'(grant), 32'h1);
        cyc();
        check("release_edge_count", 32'(count), 32'hE);
        take = 2'b00;
        cyc();
        restock = 2'b01;
        cyc();
        restock = 2'b00;
        check("refill_count", 32'(count), 32'hF);

        // Drain channel 0 with three pulses.
        for (int k = 0; k < 3; k++) begin
            pulse($sformatf("drain0_%0d", k), 2'b01, 2'b00, 2'b01, 2'b00);
            check($sformatf("drain0_cnt_%0d", k), 32'(count[1:0]), 32'(2 - k));
            check($sformatf("drain0_cnt1_%0d", k), 32'(count[3:2]), 32'd3);
            check($sformatf("drain0_low_%0d", k), 32'(low[0]), 32'(low_of(2 - k)));
        end
        check("drain0_avail", 32'(avail), 32'h2);

        pulse("deny0", 2'b01, 2'b00, 2'b00, 2'b01);
        check("deny0_cnt", 32'(count[1:0]), 32'd0);
        check("deny0_all_empty", 32'(all_empty), 32'h0);

        for (int k = 0; k < 3; k++) begin
            pulse($sformatf("drain1_%0d", k), 2'b10, 2'b00, 2'b10, 2'b00);
        end
        check("drain1_count", 32'(count), 32'h0);
        check("drain1_all_empty", 32'(all_empty), 32'h1);
        check("drain1_avail", 32'(avail), 32'h0);

        pulse("restock_both", 2'b00, 2'b11, 2'b00, 2'b00);
        check("restock_both_count", 32'(count), 32'hF);
        check("restock_both_empty", 32'(all_empty), 32'h0);

        pulse("restock_full", 2'b00, 2'b01, 2'b00, 2'b00);
        check("restock_full_count", 32'(count), 32'hF);

        // Held take consumes exactly one unit.
        gsum = 0;
        take = 2'b01;
        for (int k = 0; k < 10; k++) begin
            #1;
            gsum += int'(grant[0]);
            cyc();
        end
        take = 2'b00;
        cyc();
        check("held_grants", 32'(gsum), 32'd1);
        check("held_count", 32'(count), 32'hE);
        $display("txn held take0 10 cycles grants=%0d count=%h", gsum, count);

        pulse("to_one", 2'b01, 2'b00, 2'b01, 2'b00);
        check("to_one_count", 32'(count), 32'hD);
        pulse("restock_take", 2'b01, 2'b01, 2'b00, 2'b00);
        check("restock_take_count", 32'(count), 32'hF);

        pulse("dual", 2'b11, 2'b00, 2'b11, 2'b00);
        check("dual_count", 32'(count), 32'hA);

        take = 2'b11;
        #1;
        check("pre_rst_grant", 32'(grant), 32'h3);
        #2;
        reset1 = 1'b1;
        #1;
        check("mid_rst_count", 32'(count), 32'hF);
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_deny", 32'(deny), 32'h0);
        check("mid_rst_avail", 32'(avail), 32'h3);
        $display("txn async reset mid-cycle count=%h", count);
        cyc();
        take   = 2'b00;
        reset1 = 1'b0;
        cyc();
        check("post_rst_count", 32'(count), 32'hF);
        pulse("post_rst", 2'b10, 2'b00, 2'b10, 2'b00);
        check("post_rst_take_count", 32'(count), 32'hB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
